rcb_arb: RTL and testbench
==========================

# rcb_arb

Multi-channel successor to the RAM control block: a single-port per-symbol parameter RAM shared between NUM_RD feed-decoder lookup channels and the host config port (byte-enabled writes plus host read-back). Reads have priority. The block provides:
- round-robin fairness between read channels;
- a starvation counter guaranteeing host access;
- optional per-byte parity.

It sits between the feed decoders/comparators and the host processor bus.

## Interface
- ADDR_W, 14, RAM address width; depth = 2**ADDR_W
- DATA_W, 64, data width; multiple of 8
- NUM_RD, 2, lookup read channels (>=1)
- HOST_STARVE_MAX, 16, denied host cycles before forced host slot (>=1)

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- rd_req  in  NUM_RD  per-channel lookup request (single-cycle strobe)
- rd_addr  in  NUM_RD*ADDR_W  per-channel lookup address, channel i at [i*ADDR_W +: ADDR_W]
- rd_gnt  out  NUM_RD  combinational grant, same cycle as rd_req; one-hot or zero
- rd_vld  out  NUM_RD  registered; data valid for channel i
- rd_data  out  NUM_RD*DATA_W  registered lookup data per channel
- rd_perr  out  NUM_RD  registered parity error, qualified by rd_vld
- hpb_wr_req  in  1  host write request (level, held until done)
- hpb_wr_addr  in  ADDR_W  host write address
- hpb_wr_data  in  DATA_W  host write data
- hpb_wr_byte_en  in  DATA_W/8  byte enables
- hpb_wr_done  out  1  one-cycle write completion pulse
- hpb_rd_req  in  1  host read request (level, held until done)
- hpb_rd_addr  in  ADDR_W  host read address
- hpb_rd_done  out  1  one-cycle read completion pulse
- hpb_rd_data  out  DATA_W  host read data, valid with hpb_rd_done
- hpb_rd_perr  out  1  parity error on host read, valid with hpb_rd_done

## Operation
- One RAM access per cycle. The owner is selected combinationally from: read channel, host write, host read, or idle.
- Host eligibility:
  - A host request is eligible when its req is high and its ignore flag is clear.
  - Each ignore flag sets on acceptance and clears on the first cycle the corresponding req is low. This is the sticky handshake that prevents a re-write.
- Priority, normal:
  1. Any rd_req.
  2. Host write.
  3. Host read.
- Priority, forced: when starve_cnt == HOST_STARVE_MAX, the eligible host op wins and all rd_gnt are 0. Write beats read here too.
- Read round-robin:
  - rr_ptr holds the last granted channel.
  - Grant goes to the first requesting channel after rr_ptr, wrapping.
  - rr_ptr updates only on a read grant.
  - A request that is not granted is dropped. The requester must re-strobe; it sees rd_gnt=0.
- starve_cnt:
  - Increments (saturating at HOST_STARVE_MAX) in each cycle an eligible host op is denied.
  - Clears on any host acceptance, or when no host op is eligible.
- Writes update only the enabled bytes. A byte_en of all-zero still completes with hpb_wr_done.
- RAM contents are not reset.
- Reset mid-operation: a pending done is lost, and the ignore flags clear. The host re-issues if req is still high.

## Timing
- Access accepted in cycle T. Then in cycle T+1:
  - rd_vld[i] and rd_data[i] for a read;
  - hpb_wr_done for a host write;
  - hpb_rd_done and hpb_rd_data for a host read.
- Read data = RAM contents before any write in the same cycle. Same-cycle read and write cannot occur.
- Reset values: rd_gnt=0, rd_vld=0, rd_data=0, rd_perr=0, hpb_wr_done=0, hpb_rd_done=0, hpb_rd_data=0, hpb_rd_perr=0, starve_cnt=0, rr_ptr=NUM_RD-1, ignore flags=0.
- rd_data[i] and hpb_rd_data hold their last value when not valid.
- Host worst-case latency under saturated reads is HOST_STARVE_MAX+1 cycles from req to accept.

## Configuration
- RCB_ARB_PARITY_EN:
  - Defined:
    - The RAM stores DATA_W + DATA_W/8 bits.
    - The even parity bit of each byte is written under that byte's enable.
    - Parity is checked on every read. rd_perr or hpb_rd_perr is asserted if any byte mismatches.
  - Undefined:
    - The RAM is DATA_W wide.
    - rd_perr and hpb_rd_perr are tied to 0.

## Structure
- Package rcb_arb_pkg contains:
  - WR_EN_W=8;
  - enum rcb_op_e {OP_IDLE, OP_RD, OP_HWR, OP_HRD};
  - function byte_parity(data) returning the DATA_W/8 parity vector.
- Sub-module rr_arb (parameter N): request vector in, one-hot grant out, pointer update on an advance input.
- The BRAM is inferred inside rcb_arb.

## Test plan
- NUM_RD=2; both channels strobe every cycle for 6 cycles, addrs 0x10/0x20 preloaded 0xA/0xB -> grants alternate ch0,ch1,...; each rd_vld one cycle after its grant with the correct data.
- Host write 0x1234 holding byte_en=0x0F over 0xFFFF_FFFF_FFFF_FFFF -> hpb_wr_done at T+1; host read returns 0xFFFF_FFFF_0000_1234; req held high 5 cycles -> exactly one done.
- Continuous ch0 reads with a host write pending, HOST_STARVE_MAX=4 -> rd_gnt=0 on cycle 5; host write done on cycle 6; reads resume.
- hpb_wr_req and hpb_rd_req asserted together with no reads -> write done first, read done the following cycle returning the new data.
- Async reset asserted mid-transfer with hpb_wr_req held -> all outputs 0 immediately; after release, the write is re-accepted once.
- With RCB_ARB_PARITY_EN, force-flip bit 9 of a stored word -> next read of that address has rd_perr=1; other addresses have rd_perr=0.

Source files
------------

// File: rtl/rcb_arb_pkg.sv
// Shared types and helpers for the rcb_arb shared parameter-RAM arbiter.
// byte_parity works on a fixed maximum width; callers zero-extend and keep the low bits.
package rcb_arb_pkg;

    localparam int WR_EN_W    = 8;
    localparam int PAR_MAX_W  = 1024;
    localparam int PAR_NB_MAX = PAR_MAX_W / WR_EN_W;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_RD,
        OP_HWR,
        OP_HRD
    } rcb_op_e;

    function automatic logic [PAR_NB_MAX-1:0] byte_parity(input logic [PAR_MAX_W-1:0] data);
        logic [PAR_NB_MAX-1:0] p;
        for (int b = 0; b < PAR_NB_MAX; b++) begin
            p[b] = ^data[b*WR_EN_W +: WR_EN_W];
        end
        return p;
    endfunction

endpackage

// File: rtl/rcb_arb_rr.sv
// Round-robin arbiter: grants the first requester after the last granted index, wrapping.
// The pointer only moves when the owner actually takes the grant (advance).
module rr_arb #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic             found;
    int               best;
    int               off;

    // off is the distance past ptr; the smallest distance among requesters wins
    always_comb begin
        best = N;
        win  = ptr;
        off  = 0;
        for (int c = 0; c < N; c++) begin
            off = (c > int'(ptr)) ? c - int'(ptr) - 1 : c + N - int'(ptr) - 1;
            if (req[c] && (off < best)) begin
                best = off;
                win  = PTR_W'(c);
            end
        end
        found = (best < N);
        for (int c = 0; c < N; c++) begin
            gnt[c] = found && (int'(win) == c);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= PTR_W'(N - 1);
        end else if (advance && found) begin
            ptr <= win;
        end
    end

endmodule

// File: rtl/rcb_arb.sv
// Shared single-port parameter RAM arbitrated between NUM_RD lookup channels and the host bus.
// Optional per-byte even parity is enabled with the RCB_ARB_PARITY_EN macro.
module rcb_arb
    import rcb_arb_pkg::*;
#(
    parameter int ADDR_W          = 14,
    parameter int DATA_W          = 64,
    parameter int NUM_RD          = 2,
    parameter int HOST_STARVE_MAX = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_gnt,
    output logic [NUM_RD-1:0]        rd_vld,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_perr,
    input  logic                     hpb_wr_req,
    input  logic [ADDR_W-1:0]        hpb_wr_addr,
    input  logic [DATA_W-1:0]        hpb_wr_data,
    input  logic [DATA_W/8-1:0]      hpb_wr_byte_en,
    output logic                     hpb_wr_done,
    input  logic                     hpb_rd_req,
    input  logic [ADDR_W-1:0]        hpb_rd_addr,
    output logic                     hpb_rd_done,
    output logic [DATA_W-1:0]        hpb_rd_data,
    output logic                     hpb_rd_perr
);

    localparam int NB    = DATA_W / WR_EN_W;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(HOST_STARVE_MAX + 1);
`ifdef RCB_ARB_PARITY_EN
    localparam int RAM_W = DATA_W + NB;
`else
    localparam int RAM_W = DATA_W;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(HOST_STARVE_MAX)) ? v : v + CNT_W'(1);
    endfunction

    rcb_op_e             op;
    logic                wr_elig;
    logic                hrd_elig;
    logic                host_elig;
    logic                forced;
    logic [NUM_RD-1:0]   rr_gnt;
    logic [ADDR_W-1:0]   acc_addr;
    logic                wr_ign;
    logic                hrd_ign;
    logic [CNT_W-1:0]    starve_cnt;
    logic [NUM_RD-1:0]   rd_vld_p1;
    logic                wr_done_p1;
    logic                hrd_done_p1;
    logic [DATA_W-1:0]   rd_hold [NUM_RD];
    logic [DATA_W-1:0]   hrd_hold;
    logic [RAM_W-1:0]    mem [DEPTH];
    logic [RAM_W-1:0]    ram_q_p1;
    logic                perr_p1;

    rr_arb #(.N(NUM_RD)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (rd_req),
        .advance (op == OP_RD),
        .gnt     (rr_gnt)
    );

    // Owner selection; forcing the host only matters while a host op is still eligible
    always_comb begin
        wr_elig   = hpb_wr_req & ~wr_ign;
        hrd_elig  = hpb_rd_req & ~hrd_ign;
        host_elig = wr_elig | hrd_elig;
        forced    = host_elig && (starve_cnt == CNT_W'(HOST_STARVE_MAX));
        op        = OP_IDLE;
        if (!reset_n) begin
            op = OP_IDLE;
        end else if (forced) begin
            op = wr_elig ? OP_HWR : OP_HRD;
        end else if (|rd_req) begin
            op = OP_RD;
        end else if (wr_elig) begin
            op = OP_HWR;
        end else if (hrd_elig) begin
            op = OP_HRD;
        end
        rd_gnt   = (op == OP_RD) ? rr_gnt : '0;
        acc_addr = hpb_rd_addr;
        for (int c = 0; c < NUM_RD; c++) begin
            if (rd_gnt[c]) acc_addr = rd_addr[c*ADDR_W +: ADDR_W];
        end
    end

    // Stage p0 -> p1: control state, completion strobes and held output data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_p1   <= '0;
            wr_done_p1  <= 1'b0;
            hrd_done_p1 <= 1'b0;
            wr_ign      <= 1'b0;
            hrd_ign     <= 1'b0;
            starve_cnt  <= '0;
            hrd_hold    <= '0;
            for (int c = 0; c < NUM_RD; c++) rd_hold[c] <= '0;
        end else begin
            rd_vld_p1   <= rd_gnt;
            wr_done_p1  <= (op == OP_HWR);
            hrd_done_p1 <= (op == OP_HRD);
            wr_ign      <= (op == OP_HWR) | (wr_ign & hpb_wr_req);
            hrd_ign     <= (op == OP_HRD) | (hrd_ign & hpb_rd_req);
            if (!host_elig || (op == OP_HWR) || (op == OP_HRD)) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= sat_inc(starve_cnt);
            end
            for (int c = 0; c < NUM_RD; c++) begin
                if (rd_vld_p1[c]) rd_hold[c] <= ram_q_p1[DATA_W-1:0];
            end
            if (hrd_done_p1) hrd_hold <= ram_q_p1[DATA_W-1:0];
        end
    end

`ifdef RCB_ARB_PARITY_EN
    logic [PAR_NB_MAX-1:0] wr_par_full;
    logic [PAR_NB_MAX-1:0] rd_par_full;
    logic                  unused_par_hi;
    assign wr_par_full   = byte_parity(PAR_MAX_W'(hpb_wr_data));
    assign rd_par_full   = byte_parity(PAR_MAX_W'(ram_q_p1[DATA_W-1:0]));
    assign perr_p1       = (rd_par_full[NB-1:0] != ram_q_p1[RAM_W-1:DATA_W]);
    assign unused_par_hi = ^{wr_par_full, rd_par_full};
`else
    assign perr_p1 = 1'b0;
`endif

    // RAM: contents are never reset; the read port returns pre-write data
    always_ff @(posedge clk) begin
        if (op == OP_HWR) begin
            for (int b = 0; b < NB; b++) begin
                if (hpb_wr_byte_en[b]) begin
                    mem[hpb_wr_addr][b*WR_EN_W +: WR_EN_W] <= hpb_wr_data[b*WR_EN_W +: WR_EN_W];
`ifdef RCB_ARB_PARITY_EN
                    mem[hpb_wr_addr][DATA_W+b] <= wr_par_full[b];
`endif
                end
            end
        end
        if ((op == OP_RD) || (op == OP_HRD)) begin
            ram_q_p1 <= mem[acc_addr];
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_RD; c++) begin
            rd_data[c*DATA_W +: DATA_W] = rd_vld_p1[c] ? ram_q_p1[DATA_W-1:0] : rd_hold[c];
        end
        rd_vld      = rd_vld_p1;
        rd_perr     = rd_vld_p1 & {NUM_RD{perr_p1}};
        hpb_wr_done = wr_done_p1;
        hpb_rd_done = hrd_done_p1;
        hpb_rd_data = hrd_done_p1 ? ram_q_p1[DATA_W-1:0] : hrd_hold;
        hpb_rd_perr = hrd_done_p1 & perr_p1;
    end

endmodule

// File: tb/tb_rcb_arb.sv
// Bench for rcb_arb: directed scenarios plus a randomized phase, checked against a
// transaction-level model of the arbitration rules and RAM contents.
module tb_rcb_arb;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 64;
    localparam int NUM_RD = 2;
    localparam int HSM    = 4;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [NUM_RD-1:0]        rd_req = '0;
    logic [ADDR_W-1:0]        ra [NUM_RD];
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_gnt, rd_vld, rd_perr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [DATA_W-1:0]        rdo [NUM_RD];
    logic                     hpb_wr_req = 1'b0;
    logic [ADDR_W-1:0]        hpb_wr_addr = '0;
    logic [DATA_W-1:0]        hpb_wr_data = '0;
    logic [DATA_W/8-1:0]      hpb_wr_byte_en = '0;
    logic                     hpb_wr_done;
    logic                     hpb_rd_req = 1'b0;
    logic [ADDR_W-1:0]        hpb_rd_addr = '0;
    logic                     hpb_rd_done;
    logic [DATA_W-1:0]        hpb_rd_data;
    logic                     hpb_rd_perr;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_pack
        assign rd_addr[g*ADDR_W +: ADDR_W] = ra[g];
        assign rdo[g] = rd_data[g*DATA_W +: DATA_W];
    end

    rcb_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_RD(NUM_RD), .HOST_STARVE_MAX(HSM)) dut (
        .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_vld(rd_vld), .rd_data(rd_data), .rd_perr(rd_perr), .hpb_wr_req(hpb_wr_req),
        .hpb_wr_addr(hpb_wr_addr), .hpb_wr_data(hpb_wr_data), .hpb_wr_byte_en(hpb_wr_byte_en),
        .hpb_wr_done(hpb_wr_done), .hpb_rd_req(hpb_rd_req), .hpb_rd_addr(hpb_rd_addr),
        .hpb_rd_done(hpb_rd_done), .hpb_rd_data(hpb_rd_data), .hpb_rd_perr(hpb_rd_perr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [63:0] m_mem [int];
    logic [63:0] m_hold [NUM_RD];
    logic [63:0] m_hhold;
    int          m_ptr, m_starve, m_bad_addr;
    bit          m_wign, m_rign;
    logic [NUM_RD-1:0] e_vld, e_perr;
    bit          e_wdone, e_rdone, e_hperr;
    int          last_op, last_ch;
    int          pool [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = NUM_RD - 1; m_starve = 0; m_wign = 0; m_rign = 0;
        for (int c = 0; c < NUM_RD; c++) m_hold[c] = '0;
        m_hhold = '0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, 64'(rd_gnt), 0);
        chk({tag, "_vld"}, 64'(rd_vld), 0);
        for (int c = 0; c < NUM_RD; c++) chk({tag, "_rdata"}, rdo[c], 0);
        chk({tag, "_perr"}, 64'(rd_perr), 0);
        chk({tag, "_wdone"}, 64'(hpb_wr_done), 0);
        chk({tag, "_rdone"}, 64'(hpb_rd_done), 0);
        chk({tag, "_hdata"}, hpb_rd_data, 0);
        chk({tag, "_hperr"}, 64'(hpb_rd_perr), 0);
    endtask

    // One clock: predict owner from the rules, check the grant, then the registered results
    task automatic cycle();
        int op, ch, a;
        bit welig, relig;
        logic [NUM_RD-1:0] egnt;
        logic [63:0] d;
        #1;
        welig = hpb_wr_req && !m_wign;
        relig = hpb_rd_req && !m_rign;
        op = 0; ch = -1;
        if ((welig || relig) && m_starve >= HSM) op = welig ? 2 : 3;
        else if (rd_req != 0) begin
            op = 1;
            for (int k = 1; k <= NUM_RD; k++) begin
                int c;
                c = (m_ptr + k) % NUM_RD;
                if (ch < 0 && ((rd_req >> c) & 1) != 0) ch = c;
            end
        end
        else if (welig) op = 2;
        else if (relig) op = 3;
        egnt = (op == 1) ? (NUM_RD'(1) << ch) : '0;
        chk("rd_gnt", 64'(rd_gnt), 64'(egnt));
        e_vld = egnt; e_perr = '0; e_wdone = (op == 2); e_rdone = (op == 3); e_hperr = 0;
        if (op == 1) begin
            a = int'(ra[ch]);
            m_hold[ch] = m_mem[a];
            if (a == m_bad_addr) e_perr = egnt;
            m_ptr = ch;
        end
        if (op == 3) begin
            a = int'(hpb_rd_addr);
            m_hhold = m_mem[a];
            e_hperr = (a == m_bad_addr);
        end
        if (op == 2) begin
            a = int'(hpb_wr_addr);
            d = m_mem.exists(a) ? m_mem[a] : '0;
            for (int b = 0; b < 8; b++)
                if (((hpb_wr_byte_en >> b) & 1) != 0) d[b*8 +: 8] = hpb_wr_data[b*8 +: 8];
            m_mem[a] = d;
            if (a == m_bad_addr && hpb_wr_byte_en[1]) m_bad_addr = -1;
        end
        m_starve = (op >= 2 || !(welig || relig)) ? 0 : ((m_starve < HSM) ? m_starve + 1 : HSM);
        m_wign = (op == 2) ? 1'b1 : (hpb_wr_req ? m_wign : 1'b0);
        m_rign = (op == 3) ? 1'b1 : (hpb_rd_req ? m_rign : 1'b0);
        last_op = op; last_ch = ch;
        @(posedge clk); #1;
        chk("rd_vld", 64'(rd_vld), 64'(e_vld));
        for (int c = 0; c < NUM_RD; c++) chk("rd_data", rdo[c], m_hold[c]);
        chk("rd_perr", 64'(rd_perr), 64'(e_perr));
        chk("hpb_wr_done", 64'(hpb_wr_done), 64'(e_wdone));
        chk("hpb_rd_done", 64'(hpb_rd_done), 64'(e_rdone));
        chk("hpb_rd_data", hpb_rd_data, m_hhold);
        chk("hpb_rd_perr", 64'(hpb_rd_perr), 64'(e_hperr));
    endtask

    task automatic host_wr(input int a, input logic [63:0] d, input logic [7:0] be);
        int acc = 0;
        hpb_wr_req = 1; hpb_wr_addr = ADDR_W'(a); hpb_wr_data = d; hpb_wr_byte_en = be;
        for (int i = 0; i < 40 && acc == 0; i++) begin
            cycle();
            if (last_op == 2) acc = 1;
        end
        chk("host_wr_accept", 64'(acc), 1);
        hpb_wr_req = 0;
        cycle();
    endtask

    task automatic host_rd(input int a);
        int acc = 0;
        hpb_rd_req = 1; hpb_rd_addr = ADDR_W'(a);
        for (int i = 0; i < 40 && acc == 0; i++) begin
            cycle();
            if (last_op == 3) acc = 1;
        end
        chk("host_rd_accept", 64'(acc), 1);
        hpb_rd_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, acc, resumed, wst, rst, whold, rhold;
        logic [63:0] v;
        for (int c = 0; c < NUM_RD; c++) ra[c] = '0;
        m_bad_addr = -1;
        model_reset();
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1;

        // Preload
        host_wr('h10, 64'hA, 8'hFF);
        host_wr('h20, 64'hB, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            pool[i] = 'h100 + i * 7;
            host_wr(pool[i], {$urandom, $urandom}, 8'hFF);
        end

        // Round robin: both channels strobe every cycle
        rd_req = 2'b11; ra[0] = 'h10; ra[1] = 'h20;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("rr_alternate", 64'(last_ch), 64'(i % 2));
        end
        rd_req = '0;
        cycle();

        // Byte-enabled write, held request completes once
        host_wr('h30, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        hpb_wr_req = 1; hpb_wr_addr = 'h30; hpb_wr_data = 64'h1234; hpb_wr_byte_en = 8'h0F;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (hpb_wr_done) cnt++;
        end
        chk("wr_done_once", 64'(cnt), 1);
        hpb_wr_req = 0;
        cycle();
        host_rd('h30);
        chk("byte_en_merge", hpb_rd_data, 64'hFFFF_FFFF_0000_1234);
        cycle();

        // Starvation: continuous ch0 reads with a host write pending
        rd_req = 2'b01; ra[0] = 'h10;
        hpb_wr_req = 1; hpb_wr_addr = 'h40; hpb_wr_data = 64'hDEAD_BEEF_0BAD_F00D; hpb_wr_byte_en = 8'hFF;
        acc = 0; resumed = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (acc != 0 && i == acc + 1 && last_op == 1) resumed = 1;
            if (last_op == 2 && acc == 0) begin acc = i; hpb_wr_req = 0; end
        end
        chk("starve_accept_cycle", 64'(acc), 64'(HSM + 1));
        chk("reads_resume", 64'(resumed), 1);
        rd_req = '0;
        cycle();

        // Simultaneous host write and read: write first, read sees new data
        v = 64'h0123_4567_89AB_CDEF;
        hpb_wr_req = 1; hpb_wr_addr = 'h50; hpb_wr_data = v; hpb_wr_byte_en = 8'hFF;
        hpb_rd_req = 1; hpb_rd_addr = 'h50;
        cycle();
        chk("both_write_first", 64'(last_op), 2);
        hpb_wr_req = 0;
        cycle();
        chk("both_read_second", 64'(last_op), 3);
        chk("both_read_data", hpb_rd_data, v);
        hpb_rd_req = 0;
        cycle();

        // Asynchronous reset in the middle of a held write
        hpb_wr_req = 1; hpb_wr_addr = 'h60; hpb_wr_data = 64'h5555_AAAA_1234_5678; hpb_wr_byte_en = 8'hFF;
        cycle();
        rd_req = 2'b11;
        reset_n = 0;
        #1;
        check_zero("midreset");
        rd_req = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (hpb_wr_done) cnt++;
        end
        chk("reset_rewrite_once", 64'(cnt), 1);
        hpb_wr_req = 0;
        cycle();

        // Randomized traffic
        wst = 0; rst = 0; whold = 0; rhold = 0;
        for (int i = 0; i < 400; i++) begin
            rd_req = NUM_RD'($urandom_range(0, 3));
            for (int c = 0; c < NUM_RD; c++) ra[c] = ADDR_W'(pool[$urandom_range(0, 7)]);
            if (wst == 3) wst = 0;
            else if (wst == 0 && $urandom_range(0, 5) == 0) begin
                hpb_wr_req = 1; hpb_wr_addr = ADDR_W'(pool[$urandom_range(0, 7)]);
                hpb_wr_data = {$urandom, $urandom}; hpb_wr_byte_en = 8'($urandom); wst = 1;
            end
            if (rst == 3) rst = 0;
            else if (rst == 0 && $urandom_range(0, 5) == 0) begin
                hpb_rd_req = 1; hpb_rd_addr = ADDR_W'(pool[$urandom_range(0, 7)]); rst = 1;
            end
            cycle();
            if (wst == 1 && last_op == 2) begin wst = 2; whold = $urandom_range(0, 2); end
            else if (wst == 2) begin
                if (whold == 0) begin hpb_wr_req = 0; wst = 3; end else whold--;
            end
            if (rst == 1 && last_op == 3) begin rst = 2; rhold = $urandom_range(0, 2); end
            else if (rst == 2) begin
                if (rhold == 0) begin hpb_rd_req = 0; rst = 3; end else rhold--;
            end
        end
        rd_req = '0; hpb_wr_req = 0; hpb_rd_req = 0;
        repeat (3) cycle();

`ifdef RCB_ARB_PARITY_EN
        // Corrupt one stored bit: only that address reports a parity error
        dut.mem[14'h10][9] = ~dut.mem[14'h10][9];
        m_mem['h10] = m_mem['h10] ^ 64'h200;
        m_bad_addr = 'h10;
        rd_req = 2'b01; ra[0] = 'h10;
        cycle();
        chk("parity_bad_addr", 64'(rd_perr), 1);
        rd_req = 2'b10; ra[1] = 'h20;
        cycle();
        chk("parity_good_addr", 64'(rd_perr), 0);
        rd_req = '0;
        host_rd('h10);
        chk("parity_host_rd", 64'(hpb_rd_perr), 1);
        cycle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
